// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: writeback arbiter sharing the register file's single write
// port between requester A (ALU) and requester B (load/memory).
// Grants are combinational valid/ready; the write bundle is registered.
// Optional feature macro: RF_WB_ARB_RR_EN
//   defined   -> round-robin on a tie (grant the requester that is not last)
//   undefined -> fixed priority, A always beats B on a tie
module rf_wb_arbiter #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [RW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [RW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          hold,
  output logic          write,
  output logic [RW-1:0] writeregsel,
  output logic [DW-1:0] writedata,
  input  logic          rf_err,
  output logic          err,
  output logic          busy_a,
  output logic          busy_b
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  src_t last;
  logic grant_a;
  logic grant_b;
  logic accept;

  // Grant decision; depends only on valids, hold, reset and the last-grant flop
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst && !hold) begin
      if (a_valid && b_valid) begin
`ifdef RF_WB_ARB_RR_EN
        grant_a = (last == SRC_B);
        grant_b = (last == SRC_A);
`else
        grant_a = 1'b1;
`endif
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign accept  = grant_a | grant_b;

  // Last-grant flop, updated only on an accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= SRC_B;
    end else if (grant_a) begin
      last <= SRC_A;
    end else if (grant_b) begin
      last <= SRC_B;
    end
  end

  // Registered write bundle and source tags; payload holds while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write       <= 1'b0;
      busy_a      <= 1'b0;
      busy_b      <= 1'b0;
      writeregsel <= '0;
      writedata   <= '0;
    end else begin
      write  <= accept;
      busy_a <= grant_a;
      busy_b <= grant_b;
      if (accept) begin
        writeregsel <= grant_a ? a_reg  : b_reg;
        writedata   <= grant_a ? a_data : b_data;
      end
    end
  end

  // Sticky error flag: register file fault seen during a write cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (write && rf_err) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed bench with a behavioural model of the arbiter.
// Expected tie order follows RF_WB_ARB_RR_EN when defined.
module tb_rf_wb_arbiter;

`ifdef RF_WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0, rf_err = 1'b0;
  logic [2:0]  a_reg = '0, b_reg = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, write, err, busy_a, busy_b;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;

  int checks = 0;
  int failures = 0;

  rf_wb_arbiter #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .hold(hold), .write(write), .writeregsel(writeregsel), .writedata(writedata),
    .rf_err(rf_err), .err(err), .busy_a(busy_a), .busy_b(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        from_b;
    logic [2:0]  rsel;
    logic [15:0] data;
  } wr_t;

  wr_t  m_payload = '0;   // most recently accepted transaction
  logic m_pending = 1'b0; // an accept happened on the previous edge
  bit   m_last_b  = 1'b1; // who won the previous accept
  logic m_err     = 1'b0;

  // Who wins this cycle: 0 none, 1 A, 2 B
  function automatic int winner(input logic av, input logic bv, input logic h,
                                input logic r, input bit lb);
    if (!r || h) return 0;
    if (av && bv) return (RR && !lb) ? 2 : 1;
    if (av) return 1;
    if (bv) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_payload <= '0; m_pending <= 1'b0; m_last_b <= 1'b1; m_err <= 1'b0;
    end else begin
      int w;
      w = winner(a_valid, b_valid, hold, rst, m_last_b);
      if (m_pending && rf_err) m_err <= 1'b1;
      m_pending <= (w != 0);
      if (w == 1) begin m_payload <= '{1'b0, a_reg, a_data}; m_last_b <= 1'b0; end
      if (w == 2) begin m_payload <= '{1'b1, b_reg, b_data}; m_last_b <= 1'b1; end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    int w;
    w = winner(a_valid, b_valid, hold, rst, m_last_b);
    chk("a_ready", a_ready, (w == 1));
    chk("b_ready", b_ready, (w == 2));
    chk("write", write, m_pending);
    chk("writeregsel", writeregsel, m_payload.rsel);
    chk("writedata", writedata, m_payload.data);
    chk("busy_a", busy_a, m_pending && !m_payload.from_b);
    chk("busy_b", busy_b, m_pending && m_payload.from_b);
    chk("err", err, m_err);
  end

  // Register file image, used to read back the final value of a register
  logic [15:0] rf_img [8];
  always @(posedge clk) if (write) rf_img[writeregsel] <= writedata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [2:0] r, input logic [15:0] d);
    a_valid = v; a_reg = r; a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [2:0] r, input logic [15:0] d);
    b_valid = v; b_reg = r; b_data = d;
  endtask

  initial begin
    // Reset held 3 cycles with both requesters valid
    set_a(1'b1, 3'd1, 16'h1111);
    set_b(1'b1, 3'd2, 16'h2222);
    repeat (3) step();
    chk("rst_write", write, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_err", err, 0);

    // Release with only A valid
    rst = 1'b1;
    set_a(1'b1, 3'd3, 16'hBEEF);
    set_b(1'b0, 3'd0, 16'h0);
    #1 chk("first_a_ready", a_ready, 1);
    @(posedge clk); #1;
    set_a(1'b0, 3'd0, 16'h0);
    chk("first_write", write, 1);
    chk("first_sel", writeregsel, 3);
    chk("first_data", writedata, 16'hBEEF);
    chk("first_busy_a", busy_a, 1);

    // B alone, leaving B as last winner
    set_b(1'b1, 3'd6, 16'h0606);
    step();
    set_b(1'b0, 3'd0, 16'h0);
    chk("b_only_busy_b", busy_b, 1);

    // Tie stream for 4 cycles
    set_a(1'b1, 3'd1, 16'h1111);
    set_b(1'b1, 3'd2, 16'h2222);
    for (int i = 0; i < 4; i++) begin
      logic exp_a;
      exp_a = RR ? ((i % 2) == 0) : 1'b1;
      #1;
      chk("tie_a_ready", a_ready, exp_a);
      chk("tie_b_ready", b_ready, !exp_a);
      @(posedge clk); #1;
      chk("tie_write", write, 1);
      chk("tie_data", writedata, exp_a ? 16'h1111 : 16'h2222);
    end

    // Hold for 2 cycles with both valid
    hold = 1'b1;
    #1;
    chk("hold_a_ready", a_ready, 0);
    chk("hold_b_ready", b_ready, 0);
    chk("hold_inflight_write", write, 1);
    step();
    chk("hold_write_off", write, 0);
    step();
    chk("hold_write_off2", write, 0);
    hold = 1'b0;
    #1 chk("resume1_a_ready", a_ready, 1);
    step();
    #1 chk("resume2_b_ready", b_ready, RR);
    step();
    set_a(1'b0, 3'd0, 16'h0);
    set_b(1'b0, 3'd0, 16'h0);
    step();

    // Same-register writes: A then B to r5
    set_a(1'b1, 3'd5, 16'h00AA);
    step();
    set_a(1'b0, 3'd0, 16'h0);
    set_b(1'b1, 3'd5, 16'h00BB);
    chk("same_first_data", writedata, 16'h00AA);
    step();
    set_b(1'b0, 3'd0, 16'h0);
    chk("same_second_write", write, 1);
    chk("same_second_busy_b", busy_b, 1);
    step();
    chk("same_readback", rf_img[5], 16'h00BB);

    // Error flag: fault during a write cycle is sticky
    set_a(1'b1, 3'd1, 16'h0001);
    step();
    set_a(1'b0, 3'd0, 16'h0);
    rf_err = 1'b1;
    step();
    rf_err = 1'b0;
    chk("err_set", err, 1);
    step();
    chk("err_sticky", err, 1);
    rst = 1'b0;
    #2 chk("err_cleared", err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Reset asserted while a write is in flight
    set_a(1'b1, 3'd2, 16'h2222);
    step();
    set_a(1'b0, 3'd0, 16'h0);
    chk("midrst_write_before", write, 1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_write", write, 0);
    chk("midrst_busy_a", busy_a, 0);
    chk("midrst_busy_b", busy_b, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", write, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback arbiter for the 8×16 register file with bypass. It shares the register file's single write port between two writeback requesters: port A (ALU result) and port B (load/memory result). It uses valid/ready handshakes, grants at most one write per cycle, and drives a registered write bundle into the register file. It also samples the register file's error output and holds it as a sticky error flag.

## Interface
Parameters:
- `DW`, default 16: data width.
- `RW`, default 3: register-select width.

Ports:
- `clk`, in, 1: clock; all state is on the rising edge.
- `rst`, in, 1: reset; asynchronous, active-low.
- `a_valid`, in, 1: requester A has a write pending.
- `a_reg`, in, RW: destination register for A.
- `a_data`, in, DW: write data for A.
- `a_ready`, out, 1: A's request is accepted this cycle.
- `b_valid`, in, 1: requester B has a write pending.
- `b_reg`, in, RW: destination register for B.
- `b_data`, in, DW: write data for B.
- `b_ready`, out, 1: B's request is accepted this cycle.
- `hold`, in, 1: pipeline stall; blocks all grants.
- `write`, out, 1: register-file write enable.
- `writeregsel`, out, RW: register-file write select.
- `writedata`, out, DW: register-file write data.
- `rf_err`, in, 1: `err` output of the register file.
- `err`, out, 1: sticky error flag.
- `busy_a`, out, 1: the current `write` cycle carries A's data.
- `busy_b`, out, 1: the current `write` cycle carries B's data.

## Operation
- **Accept condition.** A request is accepted when `x_valid && x_ready`.
- **Grant rules.** `a_ready` and `b_ready` are combinational. They are never both 1, and both are 0 while `hold=1`.
  - Only one requester valid: it is granted.
  - Both valid: the arbitration policy decides (see Configuration).
  - Neither valid: no grant.
- **Last-grant flop.** `last` (0=A, 1=B) is updated only on an accepted request. Its reset value is 1, so A wins the first tie.
- **Output stage.** On an accept, the accepted `reg` and `data` load into the output flops and `write` is set to 1 for the next cycle.
  - With no accept, `write` is 0 next cycle.
  - `writeregsel` and `writedata` hold their last values while `write=0`.
- **Source tags.** `busy_a` and `busy_b` are registered alongside `write` to tag the source. At most one is 1, and only while `write=1`.
- **Error flag.** `err` is set when `write=1 && rf_err=1` at a clock edge. It stays set until reset.
- **Same-register writes.** A and B targeting the same register in consecutive cycles produce two sequential writes in grant order; the later one wins. No merging or cancellation.
- **Requester contract.**
  - Requesters must hold `valid`, `reg` and `data` stable until accepted.
  - The arbiter does not check this; a changed payload is written as presented at accept.
- **Reset values.** `write=0`, `writeregsel=0`, `writedata=0`, `busy_a=0`, `busy_b=0`, `err=0`, `last=1`. `a_ready` and `b_ready` evaluate to 0 during reset.
- **Reset mid-operation.** Asserting `rst` clears all state immediately, including an in-flight write: `write` drops asynchronously. An accept in the same cycle as reset is lost.

## Timing
- **Latency.** Accept in cycle N gives `write=1` with that payload in cycle N+1. The register file commits at the end of N+1, and its bypass makes the value readable in N+1.
- **Throughput.** One write per cycle, sustained. Back-to-back accepts produce a continuous `write=1`.
- **Ready path.** `x_ready` depends combinationally on `a_valid`, `b_valid`, `hold` and `last`. There is no combinational path from any `reg` or `data` input to any output.
- **Hold.** With `hold=1` in cycle N:
  - no accept occurs in N;
  - `write=0` in N+1;
  - a write already launched from an accept in N−1 still completes in N.
- **Error timing.** `err` rises one cycle after the faulting write cycle.

## Configuration
- Macro: `RF_WB_ARB_RR_EN`.
- **Defined (round-robin).** On a tie, grant the requester that is not `last`. Neither requester waits more than one grant while continuously valid.
- **Undefined (fixed priority).** A always beats B on a tie; B can starve while A is continuously valid. `last` is still maintained, but it does not affect grants.

## Test plan
- **Reset.** Hold `rst=0` for 3 cycles with both valid → all outputs 0, no ready. Release `rst` with `a_valid=1`, `a_reg=3`, `a_data=16'hBEEF` → `a_ready=1`; next cycle `write=1`, `writeregsel=3`, `writedata=BEEF`, `busy_a=1`.
- **Tie stream.** Both valid for 4 cycles (A: r1=0x1111, B: r2=0x2222) with `RF_WB_ARB_RR_EN` defined → grants A,B,A,B and `write` high 4 consecutive cycles. Without the macro → A,A,A,A and `b_ready` stays 0.
- **Hold.** `hold=1` for 2 cycles with both valid → no ready, and `write=0` from the cycle after `hold` rises. Release `hold` → grants resume with the correct round-robin order.
- **Same register.** A writes r5=0x00AA, then B writes r5=0x00BB in the next cycle → two writes; a register-file readback of r5 gives 0x00BB.
- **Error flag.** Force `rf_err=1` during a write cycle → `err=1` next cycle and it stays 1 with `rf_err=0`. Pulse `rst` → `err=0`.
- **Reset mid-write.** Assert `rst` asynchronously in the cycle `write=1` → `write`, `busy_a` and `busy_b` drop before the next edge, and no further write occurs after release until a new accept.
